obstacle_manager: RTL and testbench



---
 rtl/obstacle_pkg.sv | 36 +++
 rtl/obstacle_lfsr.sv | 27 ++
 rtl/obstacle_manager.sv | 236 +++++++++++++++++++++++
 tb/tb_obstacle_manager.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared obstacle slot layout, game/scan state encodings and LFSR step; also imported by track_draw.
// Pure declarations: no latency, no flow control.
package obstacle_pkg;

   localparam int TYPE_W = 2;
   localparam int POS_W  = 10;
   localparam int LANE_W = 2;
   localparam int SLOT_W = TYPE_W + POS_W + LANE_W + 1;

   typedef struct packed {
      logic [TYPE_W-1:0] kind;
      logic [POS_W-1:0]  pos;
      logic [LANE_W-1:0] lane;
      logic              active;
   } obstacle_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } game_state_t;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      SCAN  = 2'd1,
      SPAWN = 2'd2
   } scan_state_t;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Galois LFSR, reloads SEED on reset, advances one step per enabled cycle.
// Output is the registered state (low OUT_W bits); no flow control.
module obstacle_lfsr
   import obstacle_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [OUT_W-1:0] value
);

   logic [15:0] state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEED;
      end else if (enable) begin
         state <= lfsr_next(state);
      end
   end

   assign value = state[OUT_W-1:0];

endmodule

// File: rtl/obstacle_manager.sv
// Scrolls, spawns, retires and collision-checks NUM_OBSTACLES slots; one slot per cycle, NUM_OBSTACLES+1 cycles per frame.
// Frame ticks arriving while busy_out is high are dropped; DIFFICULTY_RAMP_EN adds speed ramping with score.
module obstacle_manager
   import obstacle_pkg::*;
#(
   parameter int          NUM_OBSTACLES = 10,
   parameter int          TYPE_WIDTH    = 2,
   parameter int          POS_WIDTH     = 10,
   parameter int          LANE_WIDTH    = 2,
   parameter int          NUM_LANES     = 3,
   parameter int          SPEED_WIDTH   = 3,
   parameter int          SPAWN_POS     = 1000,
   parameter int          SPAWN_GAP     = 200,
   parameter int          PLAYER_POS    = 64,
   parameter int          HIT_WIDTH     = 32,
   parameter int          SCORE_WIDTH   = 16,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
`ifdef DIFFICULTY_RAMP_EN
   , parameter int        RAMP_INTERVAL = 16
`endif
) (
   input  logic                        system_clock_in,
   input  logic                        reset_in,
   input  logic                        frame_tick_in,
   input  logic                        start_in,
   input  logic [SPEED_WIDTH-1:0]      speed_in,
   input  logic [LANE_WIDTH-1:0]       player_lane_in,
   input  logic                        jump_in,
   output logic [NUM_OBSTACLES-1:0][TYPE_WIDTH+POS_WIDTH+LANE_WIDTH:0] obstacles_out,
   output logic [SCORE_WIDTH-1:0]      score_out,
   output logic                        collision_out,
   output logic [1:0]                  game_state_out,
   output logic                        busy_out
);

   localparam int WORD_W  = TYPE_WIDTH + POS_WIDTH + LANE_WIDTH + 1;
   localparam int LANE_LO = 1;
   localparam int POS_LO  = LANE_WIDTH + 1;
   localparam int TYPE_LO = POS_LO + POS_WIDTH;
   localparam int IDX_W   = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1;
   localparam int GAP_W   = $clog2(SPAWN_GAP + 1);
   localparam logic [POS_WIDTH+1:0] HIT_LO = (POS_WIDTH+2)'(PLAYER_POS);
   localparam logic [POS_WIDTH+1:0] HIT_HI = (POS_WIDTH+2)'(PLAYER_POS + HIT_WIDTH);

   game_state_t game, game_nxt;
   scan_state_t scan, scan_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic run_entry, tick_take;

   logic [NUM_OBSTACLES-1:0][WORD_W-1:0] slots;
   logic [SCORE_WIDTH-1:0] score;
   logic [GAP_W-1:0]       gap;
   logic [SPEED_WIDTH-1:0] spd, spd_calc;
   logic                   collision;
   logic [3:0]             rnd;

   obstacle_lfsr #(.SEED(LFSR_SEED), .OUT_W(4)) u_lfsr (
      .clk    (system_clock_in),
      .reset  (reset_in),
      .enable (1'b1),
      .value  (rnd)
   );

   // Decode of the slot currently under the scan pointer.
   logic [WORD_W-1:0]     cur;
   logic [POS_WIDTH-1:0]  cur_pos, spd_pos, new_pos;
   logic [LANE_WIDTH-1:0] cur_lane;
   logic [TYPE_WIDTH-1:0] cur_type;
   logic scanning, spawning, retire, advance, in_win, hit;

   assign cur      = slots[idx];
   assign cur_pos  = cur[POS_LO +: POS_WIDTH];
   assign cur_lane = cur[LANE_LO +: LANE_WIDTH];
   assign cur_type = cur[TYPE_LO +: TYPE_WIDTH];
   assign spd_pos  = POS_WIDTH'(spd);
   assign new_pos  = cur_pos - spd_pos;

   assign scanning = (game == RUN) && (scan == SCAN);
   assign spawning = (game == RUN) && (scan == SPAWN);
   assign retire   = scanning && cur[0] && (cur_pos < spd_pos);
   assign advance  = scanning && cur[0] && !(cur_pos < spd_pos);
   assign in_win   = ({2'b00, new_pos} >= HIT_LO) && ({2'b00, new_pos} < HIT_HI);
   assign hit      = advance && in_win && (cur_lane == player_lane_in)
                     && !((cur_type == '0) && jump_in);

   // Spawn candidate: lowest free slot, gap accumulation and random lane/type.
   logic                  free_found, spawn_now;
   logic [IDX_W-1:0]      free_idx;
   logic [GAP_W-1:0]      gap_sat;
   logic [1:0]            lane_raw;
   logic [LANE_WIDTH-1:0] spawn_lane;
   logic [TYPE_WIDTH-1:0] spawn_type;
   int                    gap_sum;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
         if (!slots[i][0]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      gap_sum    = int'(gap) + int'(spd);
      gap_sat    = (gap_sum > SPAWN_GAP) ? GAP_W'(SPAWN_GAP) : GAP_W'(gap_sum);
      spawn_now  = (gap_sum >= SPAWN_GAP) && free_found;
      lane_raw   = (rnd[1:0] == 2'd3) ? 2'd1 : rnd[1:0];
      spawn_lane = (int'(lane_raw) >= NUM_LANES) ? LANE_WIDTH'(NUM_LANES - 1)
                                                 : LANE_WIDTH'(lane_raw);
      spawn_type = TYPE_WIDTH'(rnd[3:2]);
   end

   always_ff @(posedge system_clock_in) begin
      if (reset_in) begin
         game <= IDLE;
         scan <= WAIT;
         idx  <= '0;
      end else begin
         game <= game_nxt;
         scan <= scan_nxt;
         idx  <= idx_nxt;
      end
   end

   always_comb begin
      game_nxt  = game;
      scan_nxt  = scan;
      idx_nxt   = idx;
      run_entry = 1'b0;
      tick_take = 1'b0;
      case (game)
         IDLE, HALT: begin
            if (start_in) begin
               game_nxt  = RUN;
               scan_nxt  = WAIT;
               idx_nxt   = '0;
               run_entry = 1'b1;
            end
         end
         RUN: begin
            case (scan)
               WAIT: begin
                  if (frame_tick_in) begin
                     scan_nxt  = SCAN;
                     idx_nxt   = '0;
                     tick_take = 1'b1;
                  end
               end
               SCAN: begin
                  if (hit) begin
                     game_nxt = HALT;
                     scan_nxt = WAIT;
                  end else if (idx == IDX_W'(NUM_OBSTACLES - 1)) begin
                     scan_nxt = SPAWN;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
               SPAWN:   scan_nxt = WAIT;
               default: scan_nxt = WAIT;
            endcase
         end
         default: game_nxt = IDLE;
      endcase
   end

   always_ff @(posedge system_clock_in) begin
      if (reset_in) begin
         slots     <= '0;
         score     <= '0;
         gap       <= '0;
         spd       <= '0;
         collision <= 1'b0;
      end else begin
         collision <= hit;
         if (run_entry) begin
            slots <= '0;
            score <= '0;
            gap   <= '0;
         end else begin
            if (tick_take) begin
               spd <= spd_calc;
            end
            if (retire) begin
               slots[idx] <= '0;
               if (score != '1) begin
                  score <= score + 1'b1;
               end
            end else if (advance) begin
               slots[idx][POS_LO +: POS_WIDTH] <= new_pos;
            end
            if (spawning) begin
               gap <= spawn_now ? '0 : gap_sat;
               if (spawn_now) begin
                  slots[free_idx] <= {spawn_type, POS_WIDTH'(SPAWN_POS), spawn_lane, 1'b1};
               end
            end
         end
      end
   end

`ifdef DIFFICULTY_RAMP_EN
   localparam int PASS_W = $clog2(RAMP_INTERVAL + 1);
   logic [PASS_W-1:0]    pass_cnt;
   logic [SPEED_WIDTH-1:0] ramp;
   logic [SPEED_WIDTH:0]   spd_sum;

   always_ff @(posedge system_clock_in) begin
      if (reset_in || run_entry) begin
         pass_cnt <= '0;
         ramp     <= '0;
      end else if (retire) begin
         if (pass_cnt == PASS_W'(RAMP_INTERVAL - 1)) begin
            pass_cnt <= '0;
            if (ramp != '1) begin
               ramp <= ramp + 1'b1;
            end
         end else begin
            pass_cnt <= pass_cnt + 1'b1;
         end
      end
   end

   assign spd_sum  = {1'b0, speed_in} + {1'b0, ramp};
   assign spd_calc = spd_sum[SPEED_WIDTH] ? '1 : spd_sum[SPEED_WIDTH-1:0];
`else
   assign spd_calc = speed_in;
`endif

   assign obstacles_out  = (game == IDLE) ? '0 : slots;
   assign score_out      = score;
   assign collision_out  = collision;
   assign game_state_out = game;
   assign busy_out       = (game == RUN) && (scan != WAIT);

endmodule

// File: tb/tb_obstacle_manager.sv
// Directed run of obstacle_manager with a frame-level reference model feeding a scoreboard of expected frame results.
module tb_obstacle_manager;

   localparam int N  = 4;
   localparam int SW = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, tick = 1'b0, start = 1'b0, jump = 1'b0;
   logic [2:0] speed = 3'd0;
   logic [1:0] plane = 2'd3;

   logic [N-1:0][SW-1:0] obs;
   logic [15:0]          score;
   logic                 coll, busy;
   logic [1:0]           gs;

   obstacle_manager #(.NUM_OBSTACLES(N)) dut (
      .system_clock_in (clk),
      .reset_in        (reset),
      .frame_tick_in   (tick),
      .start_in        (start),
      .speed_in        (speed),
      .player_lane_in  (plane),
      .jump_in         (jump),
      .obstacles_out   (obs),
      .score_out       (score),
      .collision_out   (coll),
      .game_state_out  (gs),
      .busy_out        (busy)
   );

   int n_assert = 0;
   int n_fail   = 0;

   function automatic logic [15:0] step(input logic [15:0] s);
      logic [15:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   logic [15:0] tb_lfsr;
   always @(posedge clk) begin
      if (reset) tb_lfsr <= 16'hACE1;
      else       tb_lfsr <= step(tb_lfsr);
   end

   // Reference model, one step per frame.
   logic [1:0] m_type [N];
   int         m_pos  [N];
   logic [1:0] m_lane [N];
   logic       m_act  [N];
   int         m_score, m_gap;
   logic [1:0] m_gs = 2'd0;

   typedef struct {
      logic [N*SW-1:0] obs;
      int              score;
      logic            coll;
      logic [1:0]      gs;
      int              busy;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_type[i] = 2'd0; m_pos[i] = 0; m_lane[i] = 2'd0; m_act[i] = 1'b0;
      end
      m_score = 0;
      m_gap   = 0;
   endtask

   function automatic logic [N*SW-1:0] pack();
      logic [N*SW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         v[i*SW +: SW] = {m_type[i], 10'(m_pos[i]), m_lane[i], m_act[i]};
      return v;
   endfunction

   function automatic logic [1:0] front_lane();
      int best;
      logic [1:0] l;
      best = 1 << 20;
      l    = 2'd3;
      for (int i = 0; i < N; i++)
         if (m_act[i] && m_pos[i] < best) begin best = m_pos[i]; l = m_lane[i]; end
      return l;
   endfunction

   task automatic push_frame();
      exp_t e;
      logic [15:0] v;
      logic [1:0]  ln;
      int sp;
      v = tb_lfsr;
      for (int k = 0; k < N + 1; k++) v = step(v);
      sp = int'(speed);
      e.coll = 1'b0;
      e.busy = 0;
      if (m_gs == 2'd1) begin
         e.busy = N + 1;
         for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
               if (m_pos[i] < sp) begin
                  m_type[i] = 2'd0; m_pos[i] = 0; m_lane[i] = 2'd0; m_act[i] = 1'b0;
                  if (m_score < 65535) m_score++;
               end else begin
                  m_pos[i] = m_pos[i] - sp;
                  if (m_pos[i] >= 64 && m_pos[i] < 96 && m_lane[i] == plane &&
                      !(m_type[i] == 2'd0 && jump)) begin
                     e.coll = 1'b1;
                     e.busy = i + 1;
                     m_gs   = 2'd2;
                     break;
                  end
               end
            end
         end
         if (!e.coll) begin
            m_gap = m_gap + sp;
            if (m_gap > 200) m_gap = 200;
            if (m_gap >= 200) begin
               for (int i = 0; i < N; i++) begin
                  if (!m_act[i]) begin
                     ln = v[1:0];
                     if (ln == 2'd3) ln = 2'd1;
                     m_type[i] = v[3:2]; m_pos[i] = 1000; m_lane[i] = ln; m_act[i] = 1'b1;
                     m_gap = 0;
                     break;
                  end
               end
            end
         end
      end
      e.obs   = pack();
      e.score = m_score;
      e.gs    = m_gs;
      sb.push_back(e);
   endtask

   task automatic do_frame();
      exp_t e;
      int cnt;
      push_frame();
      tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      e = sb.pop_front();
      chk("busy_len",  64'(cnt),   64'(e.busy));
      chk("slots",     64'(obs),   64'(e.obs));
      chk("score",     64'(score), 64'(e.score));
      chk("collision", 64'(coll),  64'(e.coll));
      chk("state",     64'(gs),    64'(e.gs));
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      model_reset();
      m_gs = 2'd1;
      chk("start_slots", 64'(obs),   64'd0);
      chk("start_score", 64'(score), 64'd0);
      chk("start_state", 64'(gs),    64'd1);
      chk("start_busy",  64'(busy),  64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_slots", 64'(obs),   64'd0);
      chk("rst_score", 64'(score), 64'd0);
      chk("rst_coll",  64'(coll),  64'd0);
      chk("rst_state", 64'(gs),    64'd0);
      chk("rst_busy",  64'(busy),  64'd0);

      // Ticks in IDLE do nothing.
      speed = 3'd4;
      do_frame();

      // Speed 4: first spawn lands in slot 0 on tick 50.
      do_start();
      for (int f = 0; f < 50; f++) do_frame();
      chk("spawn_pos",    64'(obs[0][12:3]),       64'd1000);
      chk("spawn_active", 64'(obs[0][0]),          64'd1);
      chk("spawn_lane",   64'(obs[0][2:1] < 2'd3), 64'd1);

      // Speed 7: slot 0 walks down to 6 then retires; slots fill and spawns are withheld.
      speed = 3'd7;
      for (int f = 0; f < 400 && m_score < 2; f++) do_frame();
      chk("passed_two", 64'(score), 64'd2);

      // Speed 0 freezes motion and spawning.
      speed = 3'd0;
      for (int f = 0; f < 3; f++) do_frame();

      // Reset in the middle of a scan.
      tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1;
      chk("midscan_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
      m_gs = 2'd0;
      chk("mrst_slots", 64'(obs),   64'd0);
      chk("mrst_score", 64'(score), 64'd0);
      chk("mrst_state", 64'(gs),    64'd0);
      chk("mrst_busy",  64'(busy),  64'd0);
      chk("mrst_coll",  64'(coll),  64'd0);

      // Jumping player tracks the front obstacle: type 0 is cleared, others collide.
      speed = 3'd7;
      jump  = 1'b1;
      do_start();
      for (int f = 0; f < 600 && m_gs == 2'd1; f++) begin
         plane = front_lane();
         do_frame();
      end
      chk("halted", 64'(gs), 64'd2);

      // HALT: everything frozen, ticks ignored.
      for (int f = 0; f < 10; f++) do_frame();

      // Restart from HALT.
      plane = 2'd3;
      do_start();
      for (int f = 0; f < 3; f++) do_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
